// File: rtl/decode_ctrl_pipe.sv
// RV32 control decoder: merged main/ALU decode with illegal-instruction detection,
// registered into the D->E pipeline stage, plus a saturating illegal-instruction counter.
module decode_ctrl_pipe #(
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 8,
  parameter int SIZE_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic              ValidD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              count_clr,
  output logic [2:0]        ImmSrcD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [3:0]        ALUControlE,
  output logic [2:0]        Funct3E,
  output logic [SIZE_W-1:0] SizeE,
  output logic              MulDivE,
  output logic              IllegalE,
  output logic [CNT_W-1:0]  illegal_count
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001, ALU_PASSB = 4'b1010;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  logic              dec_reg_write;
  logic [1:0]        dec_result_src;
  logic              dec_mem_write;
  logic              dec_alu_src;
  logic              dec_branch;
  logic              dec_jump;
  logic [3:0]        dec_alu_ctrl;
  logic [2:0]        dec_funct3;
  logic [SIZE_W-1:0] dec_size;
  logic              dec_muldiv;
  logic              dec_illegal;
  logic [2:0]        dec_imm_src;
  logic              accept;

  assign accept = ValidD & ~StallE & ~FlushE;

  // alt selects sub/sra where the instruction form allows it
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_from_funct3 = ALU_ADD;
    case (f3)
      3'b000: alu_from_funct3 = alt ? ALU_SUB : ALU_ADD;
      3'b001: alu_from_funct3 = ALU_SLL;
      3'b010: alu_from_funct3 = ALU_SLT;
      3'b011: alu_from_funct3 = ALU_SLTU;
      3'b100: alu_from_funct3 = ALU_XOR;
      3'b101: alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
      3'b110: alu_from_funct3 = ALU_OR;
      3'b111: alu_from_funct3 = ALU_AND;
      default: alu_from_funct3 = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_result_src = 2'b00;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_alu_ctrl   = ALU_ADD;
    dec_funct3     = funct3;
    dec_size       = '0;
    dec_muldiv     = 1'b0;
    dec_illegal    = 1'b0;
    dec_imm_src    = 3'b000;
    // Every valid opcode ends in 2'b11, so non-32-bit encodings fall into the default arm.
    case (opcode)
      OP_R: begin
        dec_reg_write = 1'b1;
        if (funct7 == F7_MULDIV && ENABLE_M != 0) begin
          dec_muldiv = 1'b1;
        end else if (funct7 == F7_ZERO ||
                     (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_alu_ctrl = alu_from_funct3(funct3, funct7[5]);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_I: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001 && funct7 != F7_ZERO)
          dec_illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT)
          dec_illegal = 1'b1;
      end
      OP_LOAD: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b01;
        dec_size       = SIZE_W'(funct3);
        dec_illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm_src   = 3'b010;
        dec_size      = SIZE_W'(funct3);
        dec_illegal   = (funct3 > 3'b010);
      end
      OP_BRANCH: begin
        dec_branch   = 1'b1;
        dec_imm_src  = 3'b011;
        dec_alu_ctrl = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
        dec_illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        dec_jump       = 1'b1;
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b10;
        dec_imm_src    = 3'b100;
      end
      OP_JALR: begin
        dec_jump       = 1'b1;
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b10;
        dec_alu_src    = 1'b1;
        dec_illegal    = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm_src   = 3'b001;
        dec_alu_ctrl  = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b11;
        dec_imm_src    = 3'b001;
      end
      default: dec_illegal = 1'b1;
    endcase
    // An illegal word carries no side effects downstream; only the flag survives.
    if (dec_illegal) begin
      dec_reg_write  = 1'b0;
      dec_result_src = 2'b00;
      dec_mem_write  = 1'b0;
      dec_alu_src    = 1'b0;
      dec_branch     = 1'b0;
      dec_jump       = 1'b0;
      dec_alu_ctrl   = ALU_ADD;
      dec_funct3     = 3'b000;
      dec_size       = '0;
      dec_muldiv     = 1'b0;
      dec_imm_src    = 3'b000;
    end
  end

  assign ImmSrcD = dec_imm_src;

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ALUControlE <= 4'b0000;
      Funct3E     <= 3'b000;
      SizeE       <= '0;
      MulDivE     <= 1'b0;
      IllegalE    <= 1'b0;
    end else if (!StallE) begin
      ValidE      <= ValidD;
      RegWriteE   <= ValidD & dec_reg_write;
      ResultSrcE  <= ValidD ? dec_result_src : 2'b00;
      MemWriteE   <= ValidD & dec_mem_write;
      ALUSrcE     <= ValidD & dec_alu_src;
      BranchE     <= ValidD & dec_branch;
      JumpE       <= ValidD & dec_jump;
      ALUControlE <= ValidD ? dec_alu_ctrl : 4'b0000;
      Funct3E     <= ValidD ? dec_funct3 : 3'b000;
      SizeE       <= ValidD ? dec_size : '0;
      MulDivE     <= ValidD & dec_muldiv;
      IllegalE    <= ValidD & dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || count_clr)
      illegal_count <= '0;
    else if (accept && dec_illegal && !(&illegal_count))
      illegal_count <= illegal_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: a vector table, hand-written pipeline sequences and a
// randomized run against a reference model; two instances cover ENABLE_M=0 (CNT_W=2) and ENABLE_M=1.
module tb_decode_ctrl_pipe;
  typedef struct packed {
    logic       valid;
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       as;
    logic       br;
    logic       jp;
    logic [3:0] alu;
    logic [2:0] f3;
    logic [2:0] size;
    logic       md;
    logic       ill;
  } e_t;

  typedef struct {
    logic [31:0] instr;
    e_t          e0;
    e_t          e1;
    logic [2:0]  imm;
    logic        chk_imm;
  } vec_t;

  localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};

  logic clk, rst, ValidD, StallE, FlushE, count_clr;
  logic [31:0] InstrD;

  logic [2:0] imm0, imm1, f3_0, f3_1, sz0, sz1;
  logic v0, v1, rw0, rw1, mw0, mw1, as0, as1, br0, br1, jp0, jp1, md0, md1, il0, il1;
  logic [1:0] rs0, rs1;
  logic [3:0] alu0, alu1;
  logic [1:0] cnt0;
  logic [7:0] cnt1;
  e_t act0, act1;

  assign act0 = {v0, rw0, rs0, mw0, as0, br0, jp0, alu0, f3_0, sz0, md0, il0};
  assign act1 = {v1, rw1, rs1, mw1, as1, br1, jp1, alu1, f3_1, sz1, md1, il1};

  decode_ctrl_pipe #(.ENABLE_M(0), .CNT_W(2), .SIZE_W(3)) dut0 (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .count_clr(count_clr), .ImmSrcD(imm0), .ValidE(v0),
    .RegWriteE(rw0), .ResultSrcE(rs0), .MemWriteE(mw0), .ALUSrcE(as0),
    .BranchE(br0), .JumpE(jp0), .ALUControlE(alu0), .Funct3E(f3_0), .SizeE(sz0),
    .MulDivE(md0), .IllegalE(il0), .illegal_count(cnt0));

  decode_ctrl_pipe #(.ENABLE_M(1), .CNT_W(8), .SIZE_W(3)) dut1 (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .count_clr(count_clr), .ImmSrcD(imm1), .ValidE(v1),
    .RegWriteE(rw1), .ResultSrcE(rs1), .MemWriteE(mw1), .ALUSrcE(as1),
    .BranchE(br1), .JumpE(jp1), .ALUControlE(alu1), .Funct3E(f3_1), .SizeE(sz1),
    .MulDivE(md1), .IllegalE(il1), .illegal_count(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic e_t mk(input logic rw, input logic [1:0] rs, input logic mw, input logic as,
                            input logic br, input logic jp, input logic [3:0] alu,
                            input logic [2:0] f3, input logic [2:0] size, input logic md);
    e_t r;
    r = '{valid: 1'b1, rw: rw, rs: rs, mw: mw, as: as, br: br, jp: jp,
          alu: alu, f3: f3, size: size, md: md, ill: 1'b0};
    return r;
  endfunction

  function automatic e_t ill_e();
    e_t r;
    r = '0;
    r.valid = 1'b1;
    r.ill = 1'b1;
    return r;
  endfunction

  // Reference decode built from the instruction-set rules, independent of the RTL structure.
  function automatic e_t ref_decode(input logic [31:0] w, input bit m_en);
    e_t r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ok;
    r = '0; r.valid = 1'b1;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; ok = 1;
    case (op)
      7'h33: begin
        r.rw = 1;
        if (f7 == 7'h01) begin ok = m_en; r.md = 1; end
        else if (f7 == 7'h00) r.alu = ALU_TAB[f3];
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) r.alu = (f3 == 0) ? 4'd1 : 4'd9;
        else ok = 0;
      end
      7'h13: begin
        r.rw = 1; r.as = 1; r.alu = ALU_TAB[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin
          ok = (f7 == 0 || f7 == 7'h20);
          if (f7 == 7'h20) r.alu = 4'd9;
        end
      end
      7'h03: begin r.rw = 1; r.rs = 1; r.as = 1; r.size = f3; ok = !(f3 == 3 || f3 >= 6); end
      7'h23: begin r.mw = 1; r.as = 1; r.size = f3; ok = (f3 <= 2); end
      7'h63: begin
        r.br = 1;
        r.alu = (f3 < 4) ? 4'd1 : ((f3 >= 6) ? 4'd6 : 4'd5);
        ok = !(f3 == 2 || f3 == 3);
      end
      7'h6F: begin r.jp = 1; r.rw = 1; r.rs = 2; end
      7'h67: begin r.jp = 1; r.rw = 1; r.rs = 2; r.as = 1; ok = (f3 == 0); end
      7'h37: begin r.rw = 1; r.as = 1; r.alu = 4'd10; end
      7'h17: begin r.rw = 1; r.rs = 3; end
      default: ok = 0;
    endcase
    r.f3 = f3;
    if (!ok) r = ill_e();
    return r;
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    case (op)
      7'h23: return 3'd2;
      7'h63: return 3'd3;
      7'h6F: return 3'd4;
      7'h37, 7'h17: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit known_op(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  endfunction

  task automatic chk_e(input string nm, input e_t exp, input e_t act);
    e_t mask;
    mask = '1;
    if (exp.valid && exp.ill) begin
      mask = '0;
      mask.valid = 1; mask.rw = 1; mask.mw = 1; mask.br = 1; mask.jp = 1; mask.md = 1; mask.ill = 1;
    end
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: E bundle got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  task automatic addv(input logic [31:0] w, input e_t e0, input e_t e1, input logic [2:0] imm,
                      input logic chk);
    tbl.push_back('{w, e0, e1, imm, chk});
  endtask

  e_t lw_e, sub_e, mul_e, addi_e, auipc_e, exp0, exp1, d0, d1;
  int m0, m1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    lw_e    = mk(1, 1, 0, 1, 0, 0, 4'd0, 3'd2, 3'd2, 0);
    sub_e   = mk(1, 0, 0, 0, 0, 0, 4'd1, 3'd0, 3'd0, 0);
    mul_e   = mk(1, 0, 0, 0, 0, 0, 4'd0, 3'd0, 3'd0, 1);
    addi_e  = mk(1, 0, 0, 1, 0, 0, 4'd0, 3'd0, 3'd0, 0);
    auipc_e = mk(1, 3, 0, 0, 0, 0, 4'd0, 3'd0, 3'd0, 0);
    addv(32'h00500093, addi_e, addi_e, 3'd0, 1);
    addv(32'h40000093, addi_e, addi_e, 3'd0, 1);
    addv(32'h403100B3, sub_e, sub_e, 3'd0, 1);
    addv(32'h0020F0B3, mk(1,0,0,0,0,0,4'd2,3'd7,3'd0,0), mk(1,0,0,0,0,0,4'd2,3'd7,3'd0,0), 3'd0, 1);
    addv(32'h4020D0B3, mk(1,0,0,0,0,0,4'd9,3'd5,3'd0,0), mk(1,0,0,0,0,0,4'd9,3'd5,3'd0,0), 3'd0, 1);
    addv(32'h4030D093, mk(1,0,0,1,0,0,4'd9,3'd5,3'd0,0), mk(1,0,0,1,0,0,4'd9,3'd5,3'd0,0), 3'd0, 1);
    addv(32'h00502093, mk(1,0,0,1,0,0,4'd5,3'd2,3'd0,0), mk(1,0,0,1,0,0,4'd5,3'd2,3'd0,0), 3'd0, 1);
    addv(32'h0002A183, lw_e, lw_e, 3'd0, 1);
    addv(32'h00005003, mk(1,1,0,1,0,0,4'd0,3'd5,3'd5,0), mk(1,1,0,1,0,0,4'd0,3'd5,3'd5,0), 3'd0, 1);
    addv(32'h0020A023, mk(0,0,1,1,0,0,4'd0,3'd2,3'd2,0), mk(0,0,1,1,0,0,4'd0,3'd2,3'd2,0), 3'd2, 1);
    addv(32'h00000063, mk(0,0,0,0,1,0,4'd1,3'd0,3'd0,0), mk(0,0,0,0,1,0,4'd1,3'd0,3'd0,0), 3'd3, 1);
    addv(32'h00005063, mk(0,0,0,0,1,0,4'd5,3'd5,3'd0,0), mk(0,0,0,0,1,0,4'd5,3'd5,3'd0,0), 3'd3, 1);
    addv(32'h00006063, mk(0,0,0,0,1,0,4'd6,3'd6,3'd0,0), mk(0,0,0,0,1,0,4'd6,3'd6,3'd0,0), 3'd3, 1);
    addv(32'h000000EF, mk(1,2,0,0,0,1,4'd0,3'd0,3'd0,0), mk(1,2,0,0,0,1,4'd0,3'd0,3'd0,0), 3'd4, 1);
    addv(32'h000100E7, mk(1,2,0,1,0,1,4'd0,3'd0,3'd0,0), mk(1,2,0,1,0,1,4'd0,3'd0,3'd0,0), 3'd0, 1);
    addv(32'h000010B7, mk(1,0,0,1,0,0,4'd10,3'd1,3'd0,0), mk(1,0,0,1,0,0,4'd10,3'd1,3'd0,0), 3'd1, 1);
    addv(32'h00000197, auipc_e, auipc_e, 3'd1, 1);
    addv(32'h02208033, ill_e(), mul_e, 3'd0, 0);
    addv(32'h0220D033, ill_e(), mk(1,0,0,0,0,0,4'd0,3'd5,3'd0,1), 3'd0, 0);
    addv(32'h00000000, ill_e(), ill_e(), 3'd0, 1);
    addv(32'h0000007F, ill_e(), ill_e(), 3'd0, 1);
    addv(32'h00500092, ill_e(), ill_e(), 3'd0, 1);
    addv(32'h00003003, ill_e(), ill_e(), 3'd0, 0);
    addv(32'h00003023, ill_e(), ill_e(), 3'd0, 0);
    addv(32'h00002063, ill_e(), ill_e(), 3'd0, 0);
    addv(32'h00001067, ill_e(), ill_e(), 3'd0, 0);
    addv(32'h40309093, ill_e(), ill_e(), 3'd0, 0);
    addv(32'h400010B3, ill_e(), ill_e(), 3'd0, 0);
    addv(32'h2030D093, ill_e(), ill_e(), 3'd0, 0);

    rst = 1; ValidD = 0; StallE = 0; FlushE = 0; count_clr = 0; InstrD = 32'h0;
    step();
    rst = 0;
    chk_e("reset_e0", '0, act0);
    chk_e("reset_e1", '0, act1);
    chk_v("reset_cnt0", 32'(cnt0), 0);
    chk_v("reset_cnt1", 32'(cnt1), 0);
    $display("txn reset: E cleared, counts %0d/%0d", cnt0, cnt1);

    foreach (tbl[i]) begin
      InstrD = tbl[i].instr; ValidD = 1;
      #1;
      if (tbl[i].chk_imm) begin
        chk_v("imm_src0", 32'(imm0), 32'(tbl[i].imm));
        chk_v("imm_src1", 32'(imm1), 32'(tbl[i].imm));
      end
      step();
      chk_e("table_e0", tbl[i].e0, act0);
      chk_e("table_e1", tbl[i].e1, act1);
      $display("txn table %0d instr=%h E0=%h E1=%h", i, tbl[i].instr, act0, act1);
    end

    // Stall holds the loaded lw while the next instruction waits in decode.
    InstrD = 32'h0002A183; ValidD = 1;
    step();
    chk_e("stall_load", lw_e, act0);
    StallE = 1; InstrD = 32'h403100B3;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_e("stall_hold0", lw_e, act0);
      chk_e("stall_hold1", lw_e, act1);
      $display("txn stall cycle %0d E0=%h", k, act0);
    end
    StallE = 0;
    step();
    chk_e("stall_release", sub_e, act0);
    $display("txn stall release E0=%h", act0);

    InstrD = 32'h0020A023; StallE = 1; FlushE = 1;
    step();
    chk_e("flush_over_stall0", '0, act0);
    chk_e("flush_over_stall1", '0, act1);
    $display("txn flush+stall E0=%h", act0);
    StallE = 0; FlushE = 0;

    count_clr = 1; ValidD = 0;
    step();
    count_clr = 0; ValidD = 1; InstrD = 32'h02208033;
    step();
    chk_e("mul_m0", ill_e(), act0);
    chk_e("mul_m1", mul_e, act1);
    chk_v("mul_cnt0", 32'(cnt0), 1);
    chk_v("mul_cnt1", 32'(cnt1), 0);
    $display("txn mul E0=%h E1=%h counts %0d/%0d", act0, act1, cnt0, cnt1);

    count_clr = 1; ValidD = 0;
    step();
    count_clr = 0; ValidD = 1; InstrD = 32'h00000000;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_v("sat_cnt0", 32'(cnt0), (k < 3) ? k : 3);
      chk_v("sat_cnt1", 32'(cnt1), k);
      $display("txn illegal %0d counts %0d/%0d", k, cnt0, cnt1);
    end
    count_clr = 1;
    step();
    chk_v("clr_prio_cnt0", 32'(cnt0), 0);
    chk_v("clr_prio_cnt1", 32'(cnt1), 0);
    $display("txn clear+illegal counts %0d/%0d", cnt0, cnt1);
    count_clr = 0;

    step();
    InstrD = 32'h00500093;
    step();
    chk_e("pre_reset_e", addi_e, act0);
    chk_v("pre_reset_cnt0", 32'(cnt0), 1);
    rst = 1;
    step();
    rst = 0;
    chk_e("mid_reset_e0", '0, act0);
    chk_e("mid_reset_e1", '0, act1);
    chk_v("mid_reset_cnt0", 32'(cnt0), 0);
    chk_v("mid_reset_cnt1", 32'(cnt1), 0);
    $display("txn mid-stream reset E0=%h counts %0d/%0d", act0, cnt0, cnt1);
    InstrD = 32'h00000197;
    #1;
    chk_v("auipc_imm", 32'(imm0), 1);
    step();
    chk_e("auipc_e", auipc_e, act0);
    $display("txn auipc E0=%h", act0);

    // Randomized run against the reference model.
    rst = 1; ValidD = 0;
    step();
    rst = 0;
    exp0 = '0; exp1 = '0; m0 = 0; m1 = 0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      logic [6:0] ops [10];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
      w = $urandom();
      case ($urandom_range(0, 9))
        9: ;
        default: w[6:0] = ops[$urandom_range(0, 8)];
      endcase
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
      InstrD = w;
      ValidD = ($urandom_range(0, 4) != 0);
      StallE = ($urandom_range(0, 4) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      count_clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 49) == 0);
      d0 = ref_decode(w, 0);
      d1 = ref_decode(w, 1);
      #1;
      if (!d0.ill || !known_op(w[6:0])) chk_v("rnd_imm0", 32'(imm0), 32'(d0.ill ? 3'd0 : ref_imm(w[6:0])));
      if (!d1.ill || !known_op(w[6:0])) chk_v("rnd_imm1", 32'(imm1), 32'(d1.ill ? 3'd0 : ref_imm(w[6:0])));
      if (rst) begin
        exp0 = '0; exp1 = '0; m0 = 0; m1 = 0;
      end else begin
        if (FlushE) begin exp0 = '0; exp1 = '0; end
        else if (!StallE) begin exp0 = ValidD ? d0 : '0; exp1 = ValidD ? d1 : '0; end
        if (count_clr) begin m0 = 0; m1 = 0; end
        else if (ValidD && !StallE && !FlushE) begin
          if (d0.ill && m0 < 3) m0++;
          if (d1.ill && m1 < 255) m1++;
        end
      end
      step();
      chk_e("rnd_e0", exp0, act0);
      chk_e("rnd_e1", exp1, act1);
      chk_v("rnd_cnt0", 32'(cnt0), m0);
      chk_v("rnd_cnt1", 32'(cnt1), m1);
      $display("txn rnd %0d instr=%h v=%b s=%b f=%b c=%b r=%b E0=%h counts %0d/%0d",
               n, w, ValidD, StallE, FlushE, count_clr, rst, act0, cnt0, cnt1);
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
